transaction_responder: RTL and testbench
========================================

# transaction_responder

Memory-side responder for the CPU transaction control bus (read, write, byte-write-enable). Accepts one transaction at a time from the initiator, inserts a programmable number of wait states, performs the read or byte-masked write on an internal word-organised RAM, and returns a one-cycle completion pulse with read data. Sits between the CPU bus port and on-chip scratch memory; it is the reference slave used to bring up and verify the initiator side.

## Interface
Parameters:
- DEPTH, 1024, number of 32-bit words in the internal RAM; power of two, at least 2.
- WAIT_STATES, 2, idle cycles inserted between acceptance and access; range 0–15.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- read  in  1  read request (control bus `read`).
- write  in  1  write request (control bus `write`).
- bwe  in  4  byte write enables; bwe[3]=byte0=data[31:24] … bwe[0]=byte3=data[7:0] (big-endian lanes).
- address  in  32  byte address; bits [1:0] ignored; word index = address[log2(DEPTH)+1:2].
- writeData  in  32  write data.
- readData  out  32  read result; valid only in the cycle where ready=1.
- ready  out  1  one-cycle completion pulse.
- busy  out  1  high from acceptance until the cycle after ready.
- error  out  1  qualifies ready; high only together with ready.

## Operation
- States: IDLE, WAIT, ACCESS. Reset enters IDLE.
- IDLE: when read|write is high, latch read, write, bwe, address and writeData, set busy=1, then go to WAIT if WAIT_STATES>0, else ACCESS. Request inputs are ignored in WAIT and ACCESS.
- WAIT: a 4-bit counter loaded with WAIT_STATES-1 on acceptance decrements each cycle. Go to ACCESS when the counter is 0.
- ACCESS: perform the latched operation, pulse ready, then return to IDLE.
  - Read: readData = RAM[word].
  - Write: each byte lane with bwe bit 1 is updated; other lanes are unchanged. readData = 0.
- Error and edge cases, all handled in ACCESS:
  - read and write both high: error=1, no RAM change, readData=0.
  - Address at or above DEPTH*4 (any upper address bit set): error=1, no RAM change, readData=0.
  - write with bwe=0000: completes normally with error=0 and no RAM change (a NO_OP write).
  - bwe is ignored on a read.
- RAM contents are not initialised and are not cleared by reset.

## Timing
- Reset values: readData=0, ready=0, busy=0, error=0, state=IDLE, counter=0.
- Latency: a request sampled at rising edge N produces ready=1 during cycle N+1+WAIT_STATES.
- busy: rises in the cycle after edge N and falls in the cycle after ready.
- Back-to-back: a request held high through the ready cycle is accepted at the edge that ends that cycle. Maximum throughput is one transaction every 2+WAIT_STATES cycles.
- readData, ready and error are registered and return to 0 in the cycle after the pulse.
- The write takes effect at the edge that ends the ACCESS cycle. A read of the same word accepted afterwards returns the new data.
- Reset asserted mid-transaction (any state): outputs go to 0 immediately and asynchronously, and the pending transaction is dropped. A write not yet at its ACCESS edge is not performed. After reset deasserts, the first edge samples requests in IDLE.

## Test plan
- Write DWORD 0x11223344 to address 0x10, then read 0x10 with WAIT_STATES=2 -> ready exactly 3 cycles after each acceptance; read returns 0x11223344 with error=0.
- Over word 0x11223344, write BYTE0 with data 0xAA000000, then WORD1 with data 0x0000BEEF -> read returns 0xAA22BEEF.
- Address 0x0000_1000 with DEPTH=1024 -> ready=1, error=1, readData=0; a following read of 0x0 shows word 0 unchanged.
- read=1 and write=1 together -> error=1, RAM unchanged. write with bwe=0000 -> ready=1, error=0, RAM unchanged.
- WAIT_STATES=0 with a held read request -> ready every 2nd cycle and busy toggles correctly; new requests arriving while busy are not accepted.
- Assert reset during WAIT of a write to 0x20 holding 0x5555AAAA -> all outputs 0 at once, and a read after reset returns 0x5555AAAA.

Source files
------------

// File: rtl/transaction_responder.sv
// Memory-side responder for the CPU transaction bus: one outstanding request, programmable
// wait states, byte-lane masked writes into a word RAM, registered one-cycle completion.
module transaction_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  bwe,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        ready,
  output logic        busy,
  output logic        error
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t        state_r;
  logic [3:0]    cnt_r;
  logic          rd_r;
  logic          wr_r;
  logic [3:0]    bwe_r;
  logic [31:0]   addr_r;
  logic [31:0]   wdata_r;
  logic [31:0]   read_data_r;
  logic          ready_r;
  logic          busy_r;
  logic          error_r;
  logic [31:0]   mem_r [DEPTH];

  logic [AW-1:0] word_s;
  logic          range_err_s;
  logic          op_err_s;
  logic          err_s;
  logic          do_write_s;

  // Lane i of the enable vector owns bits [8i+7:8i], so bwe[3] steers the big-endian byte 0.
  function automatic logic [31:0] merge_lanes(input logic [31:0] cur,
                                              input logic [31:0] upd,
                                              input logic [3:0]  en);
    logic [31:0] mask;
    mask = {{8{en[3]}}, {8{en[2]}}, {8{en[1]}}, {8{en[0]}}};
    return (cur & ~mask) | (upd & mask);
  endfunction

  // Decode the latched request: word index and the two error sources.
  always_comb begin
    word_s      = addr_r[AW+1:2];
    range_err_s = (addr_r >> (AW + 2)) != 32'd0;
    op_err_s    = rd_r & wr_r;
    err_s       = op_err_s | range_err_s;
    do_write_s  = (state_r == ACCESS) && wr_r && !err_s;
  end

  // Control FSM with registered completion outputs; reset drops any pending request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      rd_r        <= 1'b0;
      wr_r        <= 1'b0;
      bwe_r       <= 4'd0;
      addr_r      <= 32'd0;
      wdata_r     <= 32'd0;
      read_data_r <= 32'd0;
      ready_r     <= 1'b0;
      busy_r      <= 1'b0;
      error_r     <= 1'b0;
    end else begin
      read_data_r <= 32'd0;
      ready_r     <= 1'b0;
      error_r     <= 1'b0;
      case (state_r)
        IDLE: begin
          if (read || write) begin
            rd_r    <= read;
            wr_r    <= write;
            bwe_r   <= bwe;
            addr_r  <= address;
            wdata_r <= writeData;
            busy_r  <= 1'b1;
            cnt_r   <= WS_LOAD;
            state_r <= (WAIT_STATES > 0) ? WAIT : ACCESS;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        WAIT: begin
          if (cnt_r == 4'd0) begin
            state_r <= ACCESS;
          end else begin
            cnt_r   <= cnt_r - 4'd1;
          end
        end
        ACCESS: begin
          // busy stays high through the ready cycle and falls only if nothing is accepted then
          ready_r     <= 1'b1;
          error_r     <= err_s;
          read_data_r <= (rd_r && !err_s) ? mem_r[word_s] : 32'd0;
          cnt_r       <= 4'd0;
          state_r     <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          cnt_r   <= 4'd0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Scratch RAM write port; contents survive reset by design.
  always_ff @(posedge clk) begin
    if (do_write_s) begin
      mem_r[word_s] <= merge_lanes(mem_r[word_s], wdata_r, bwe_r);
    end
  end

  assign readData = read_data_r;
  assign ready    = ready_r;
  assign busy     = busy_r;
  assign error    = error_r;

endmodule

// File: tb/tb_transaction_responder.sv
// Bench for transaction_responder: two instances (2 and 0 wait states) driven by directed and
// random transactions, checked against a word-array model of the scratch RAM.
module tb_transaction_responder;
  localparam int DEPTH = 1024;
  localparam int WS_A  = 2;
  localparam int WS_B  = 0;
  localparam int WIN   = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  rd_s;
  logic [1:0]  wr_s;
  logic [1:0]  ready_s;
  logic [1:0]  busy_s;
  logic [1:0]  error_s;
  logic [3:0]  bwe_s   [2];
  logic [31:0] addr_s  [2];
  logic [31:0] wdata_s [2];
  logic [31:0] rdata_s [2];

  logic [31:0] model_m [2][WIN];
  logic [31:0] last_rd;
  int          tests_r = 0;
  int          fails_r = 0;

  always #5 clk = ~clk;

  transaction_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS_A)) dut_a (
    .clk(clk), .reset(rst_n), .read(rd_s[0]), .write(wr_s[0]), .bwe(bwe_s[0]),
    .address(addr_s[0]), .writeData(wdata_s[0]), .readData(rdata_s[0]),
    .ready(ready_s[0]), .busy(busy_s[0]), .error(error_s[0])
  );

  transaction_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS_B)) dut_b (
    .clk(clk), .reset(rst_n), .read(rd_s[1]), .write(wr_s[1]), .bwe(bwe_s[1]),
    .address(addr_s[1]), .writeData(wdata_s[1]), .readData(rdata_s[1]),
    .ready(ready_s[1]), .busy(busy_s[1]), .error(error_s[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_r++;
    if (got !== exp) begin
      fails_r++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ws_of(input int k);
    return (k == 0) ? WS_A : WS_B;
  endfunction

  // Byte lane i (bwe bit i) is data bits [8i+7:8i].
  function automatic logic [31:0] apply_bwe(input logic [31:0] cur, input logic [31:0] d,
                                            input logic [3:0] be);
    logic [31:0] res;
    res = cur;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = d[8*i +: 8];
    end
    return res;
  endfunction

  task automatic drive_idle(input int k);
    rd_s[k]    = 1'b0;
    wr_s[k]    = 1'b0;
    bwe_s[k]   = 4'd0;
    addr_s[k]  = 32'd0;
    wdata_s[k] = 32'd0;
  endtask

  task automatic check_idle_outputs(input int k, input string tag);
    check({tag, "_busy"},  32'(busy_s[k]),  32'd0);
    check({tag, "_ready"}, 32'(ready_s[k]), 32'd0);
    check({tag, "_error"}, 32'(error_s[k]), 32'd0);
    check({tag, "_rdata"}, rdata_s[k],      32'd0);
  endtask

  // Called away from a rising edge with the instance idle; steps a fixed cycle budget.
  task automatic do_txn(input int k, input logic r, input logic w, input logic [3:0] be,
                        input logic [31:0] a, input logic [31:0] d, input bit noise);
    int          ws;
    int          widx;
    bit          err;
    logic [31:0] exp_rd;
    ws     = ws_of(k);
    err    = (r && w) || (a >= 32'(DEPTH * 4));
    widx   = int'(a[5:2]);
    exp_rd = (r && !err) ? model_m[k][widx] : 32'd0;
    rd_s[k]    = r;
    wr_s[k]    = w;
    bwe_s[k]   = be;
    addr_s[k]  = a;
    wdata_s[k] = d;
    @(posedge clk);
    for (int j = 0; j <= ws + 2; j++) begin
      @(negedge clk);
      check("busy",  32'(busy_s[k]),  32'(j <= ws + 1));
      check("ready", 32'(ready_s[k]), 32'(j == ws + 1));
      check("error", 32'(error_s[k]), (j == ws + 1) ? 32'(err) : 32'd0);
      check("rdata", rdata_s[k],      (j == ws + 1) ? exp_rd : 32'd0);
      if (j == ws + 1) last_rd = rdata_s[k];
      if (j == 0) begin
        if (noise) begin
          rd_s[k]    = 1'($urandom);
          wr_s[k]    = 1'b1;
          bwe_s[k]   = 4'hF;
          addr_s[k]  = 32'($urandom_range(0, WIN - 1)) * 32'd4;
          wdata_s[k] = $urandom;
        end else begin
          drive_idle(k);
        end
      end else if (j == ws + 1) begin
        drive_idle(k);
      end
    end
    if (w && !err) model_m[k][widx] = apply_bwe(model_m[k][widx], d, be);
  endtask

  task automatic random_txn(input int k);
    int          op;
    logic        r;
    logic        w;
    logic [31:0] a;
    op = $urandom_range(0, 19);
    a  = 32'($urandom_range(0, WIN - 1)) * 32'd4 + 32'($urandom_range(0, 3));
    r  = (op <= 8) || (op == 17);
    w  = (op >= 9 && op <= 17);
    if (op >= 18) begin
      a = $urandom | (32'h0000_1000 << $urandom_range(0, 19));
      r = (op == 18);
      w = (op == 19);
    end
    do_txn(k, r, w, 4'($urandom), a, $urandom, ($urandom_range(0, 3) == 0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int          hold_words;
    logic [31:0] exp_rd;
    rst_n = 1'b0;
    drive_idle(0);
    drive_idle(1);
    repeat (2) @(negedge clk);
    check_idle_outputs(0, "reset_a");
    check_idle_outputs(1, "reset_b");
    rst_n = 1'b1;
    @(negedge clk);

    // Give every word in the test window a known value.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < WIN; i++) do_txn(k, 1'b0, 1'b1, 4'hF, 32'(i * 4), $urandom, 1'b0);
    end

    do_txn(0, 1'b0, 1'b1, 4'hF, 32'h10, 32'h1122_3344, 1'b0);
    do_txn(0, 1'b1, 1'b0, 4'hF, 32'h10, 32'd0, 1'b0);
    check("dword_rd", last_rd, 32'h1122_3344);
    do_txn(0, 1'b0, 1'b1, 4'b1000, 32'h10, 32'hAA00_0000, 1'b1);
    do_txn(0, 1'b0, 1'b1, 4'b0011, 32'h12, 32'h0000_BEEF, 1'b0);
    do_txn(0, 1'b1, 1'b0, 4'b0101, 32'h10, 32'd0, 1'b0);
    check("lanes_rd", last_rd, 32'hAA22_BEEF);

    do_txn(0, 1'b0, 1'b1, 4'hF, 32'h0000_1000, 32'hDEAD_BEEF, 1'b0);
    do_txn(0, 1'b1, 1'b0, 4'hF, 32'h0, 32'd0, 1'b0);
    do_txn(0, 1'b1, 1'b1, 4'hF, 32'h10, 32'h0102_0304, 1'b0);
    do_txn(0, 1'b0, 1'b1, 4'h0, 32'h10, 32'hFFFF_FFFF, 1'b0);
    do_txn(0, 1'b1, 1'b0, 4'h0, 32'h10, 32'd0, 1'b1);
    check("unchanged_rd", last_rd, 32'hAA22_BEEF);

    // Held read on the zero-wait instance: one completion every second cycle.
    exp_rd     = model_m[1][3];
    hold_words = 8;
    rd_s[1]    = 1'b1;
    addr_s[1]  = 32'h0C;
    bwe_s[1]   = 4'($urandom);
    @(posedge clk);
    for (int j = 0; j < hold_words; j++) begin
      @(negedge clk);
      check("hold_busy",  32'(busy_s[1]),  32'd1);
      check("hold_ready", 32'(ready_s[1]), 32'(j % 2 == 1));
      check("hold_rdata", rdata_s[1],      (j % 2 == 1) ? exp_rd : 32'd0);
      if (j == hold_words - 1) drive_idle(1);
    end
    @(negedge clk);
    check_idle_outputs(1, "hold_end");

    // Reset while a write sits in WAIT: outputs clear at once and the write is dropped.
    do_txn(0, 1'b0, 1'b1, 4'hF, 32'h20, 32'h5555_AAAA, 1'b0);
    wr_s[0]    = 1'b1;
    bwe_s[0]   = 4'hF;
    addr_s[0]  = 32'h20;
    wdata_s[0] = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    check("pre_rst_busy", 32'(busy_s[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_idle_outputs(0, "async_rst");
    drive_idle(0);
    @(negedge clk);
    rst_n = 1'b1;
    do_txn(0, 1'b1, 1'b0, 4'hF, 32'h20, 32'd0, 1'b0);
    check("post_rst_rd", last_rd, 32'h5555_AAAA);

    for (int i = 0; i < 40; i++) random_txn(0);
    for (int i = 0; i < 30; i++) random_txn(1);

    $display("[TB] %0d tests run, %0d failed", tests_r, fails_r);
    $finish;
  end

endmodule
